// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: write-back states,
// machine-mode CSR addresses and trap constants.
package pipe_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_TRAP     = 2'd1,
        S_REDIRECT = 2'd2,
        S_HALT     = 2'd3
    } wbu_state_t;

    localparam logic [11:0] MSTATUS = 12'h300;
    localparam logic [11:0] MTVEC   = 12'h305;
    localparam logic [11:0] MEPC    = 12'h341;
    localparam logic [11:0] MCAUSE  = 12'h342;

    localparam logic [31:0] MCAUSE_ECALL = 32'd11;
    localparam int          INSTRET_W    = 64;

endpackage

// File: rtl/wbu_pipeline_if.sv
// Retired-instruction handshake from load-store
// into the write-back stage.
interface wbu_pipeline_if;

    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        reg_wen;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        ebreak;
    logic        ecall;
    logic        mret;

    modport master (
        output valid, pc, inst, result, rd,
        output reg_wen, csr_wen, csr_addr, csr_wdata,
        output ebreak, ecall, mret,
        input  ready
    );

    modport slave (
        input  valid, pc, inst, result, rd,
        input  reg_wen, csr_wen, csr_addr, csr_wdata,
        input  ebreak, ecall, mret,
        output ready
    );

endinterface

// File: rtl/wbu_trap_ctrl.sv
// Write-back control FSM: trap entry, redirect and
// flush sequencing, and the sticky halt on ebreak.
module wbu_trap_ctrl
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        accept,
    input  logic        is_ecall,
    input  logic        is_mret,
    input  logic        is_ebreak,
    input  logic [31:0] pc,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    output logic        ready,
    output logic        trap_wen,
    output logic [31:0] trap_mepc,
    output logic [31:0] trap_mcause,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        halt
);

    wbu_state_t  state;
    wbu_state_t  state_nxt;
    logic [31:0] epc_q;
    logic [31:0] target_q;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // trap pc at accept; redirect target from mepc
    // (mret, at accept) or mtvec (ecall, in S_TRAP)
    always_ff @(posedge clk) begin
        if (rst) begin
            epc_q    <= '0;
            target_q <= '0;
        end else begin
            if (accept) begin
                epc_q <= pc;
            end
            if (accept && is_mret) begin
                target_q <= csr_mepc;
            end else if (state == S_TRAP) begin
                target_q <= csr_mtvec;
            end
        end
    end

    // next-state selection
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        is_ecall:  state_nxt = S_TRAP;
                        is_mret:   state_nxt = S_REDIRECT;
                        is_ebreak: state_nxt = S_HALT;
                        default:   state_nxt = S_IDLE;
                    endcase
                end
            end
            S_TRAP:     state_nxt = S_REDIRECT;
            S_REDIRECT: state_nxt = S_IDLE;
            S_HALT:     state_nxt = S_HALT;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // state-decoded pulses and data
    always_comb begin
        ready          = (state == S_IDLE);
        trap_wen       = (state == S_TRAP);
        redirect_valid = (state == S_REDIRECT);
        flush          = (state == S_REDIRECT);
        halt           = (state == S_HALT);
        trap_mepc      = epc_q;
        trap_mcause    = trap_wen ? MCAUSE_ECALL : '0;
        redirect_pc    = target_q;
    end

endmodule

// File: rtl/wbu_pipeline.sv
// Write-back / commit stage: architectural register
// and CSR updates, commit trace, instret counter.
module wbu_pipeline
    import pipe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    wbu_pipeline_if.slave        in_if,
    input  logic [31:0]          csr_mtvec,
    input  logic [31:0]          csr_mepc,
    output logic                 rf_wen,
    output logic [4:0]           rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic                 csr_wen,
    output logic [11:0]          csr_waddr,
    output logic [31:0]          csr_wdata,
    output logic                 trap_wen,
    output logic [31:0]          trap_mepc,
    output logic [31:0]          trap_mcause,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic                 flush,
    output logic                 halt,
    output logic                 commit_valid,
    output logic [31:0]          commit_pc,
    output logic [31:0]          commit_inst,
    output logic [INSTRET_W-1:0] instret
);

    logic ready;
    logic accept;
    logic no_write;

    assign in_if.ready = ready;
    assign accept      = in_if.valid && ready;
    // ecall and ebreak never touch GPRs or CSRs
    assign no_write    = in_if.ecall || in_if.ebreak;

    wbu_trap_ctrl u_trap_ctrl (
        .clk            (clk),
        .rst            (rst),
        .accept         (accept),
        .is_ecall       (in_if.ecall),
        .is_mret        (in_if.mret),
        .is_ebreak      (in_if.ebreak),
        .pc             (in_if.pc),
        .csr_mtvec      (csr_mtvec),
        .csr_mepc       (csr_mepc),
        .ready          (ready),
        .trap_wen       (trap_wen),
        .trap_mepc      (trap_mepc),
        .trap_mcause    (trap_mcause),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .halt           (halt)
    );

    // commit trace pulse and retired-instruction count
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            commit_inst  <= '0;
            instret      <= '0;
        end else begin
            commit_valid <= accept;
            if (accept) begin
                commit_pc   <= in_if.pc;
                commit_inst <= in_if.inst;
                instret     <= instret + INSTRET_W'(1);
            end
        end
    end

    // GPR write port; x0 is never written
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= accept && in_if.reg_wen
                      && (in_if.rd != 5'd0) && !no_write;
            if (accept) begin
                rf_waddr <= in_if.rd;
                rf_wdata <= in_if.result;
            end
        end
    end

    // CSR write port
    always_ff @(posedge clk) begin
        if (rst) begin
            csr_wen   <= 1'b0;
            csr_waddr <= '0;
            csr_wdata <= '0;
        end else begin
            csr_wen <= accept && in_if.csr_wen && !no_write;
            if (accept) begin
                csr_waddr <= in_if.csr_addr;
                csr_wdata <= in_if.csr_wdata;
            end
        end
    end

endmodule

// File: doc/wbu_pipeline.md
Name: wbu_pipeline

Overview:
- Write-back / commit stage of the 5-stage pipeline, directly downstream of the load-store stage.
- Consumes one retired instruction per valid/ready handshake and performs the architectural updates:
  - GPR write-port pulse
  - CSR write pulse
  - mepc/mcause trap writes
  - redirect and flush of upstream stages for ecall and mret
  - halt on ebreak
- Also keeps the 64-bit retired-instruction counter and emits a one-cycle commit trace.

Parameters:
- MCAUSE_ECALL, 32'd11, mcause value written on ecall from M-mode
- INSTRET_W, 64, width of retired-instruction counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- in_pc  in  32  instruction PC
- in_inst  in  32  instruction word
- in_result  in  32  GPR write-back data
- in_rd  in  5  destination register
- in_reg_wen  in  1  GPR write request
- in_csr_wen  in  1  CSR write request
- in_csr_addr  in  12  CSR address
- in_csr_wdata  in  32  CSR write data
- in_ebreak / in_ecall / in_mret  in  1 each  system-instruction flags (mutually exclusive)
- csr_mtvec  in  32  current mtvec
- csr_mepc  in  32  current mepc
- rf_wen  out  1  GPR write pulse
- rf_waddr  out  5  GPR write address
- rf_wdata  out  32  GPR write data
- csr_wen  out  1  CSR write pulse
- csr_waddr  out  12  CSR write address
- csr_wdata  out  32  CSR write data
- trap_wen  out  1  pulse: write mepc and mcause
- trap_mepc  out  32  value for mepc
- trap_mcause  out  32  value for mcause
- redirect_valid  out  1  pulse: fetch from redirect_pc
- redirect_pc  out  32  redirect target
- flush  out  1  pulse: squash all upstream stages
- halt  out  1  sticky after ebreak commit
- commit_valid  out  1  one pulse per retired instruction
- commit_pc  out  32  PC of retired instruction
- commit_inst  out  32  word of retired instruction
- instret  out  64  retired-instruction count

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: all pulse outputs 0, halt 0, instret 0, all data outputs 0, state S_IDLE.
- Ready: in_ready = (state == S_IDLE). Accept happens when in_valid && in_ready.
- Accept at cycle T (registered outputs), at T+1:
  - commit_valid=1 with commit_pc/commit_inst.
  - rf_wen = in_reg_wen && (in_rd != 0). x0 is never written, even if asserted upstream.
  - csr_wen = in_csr_wen. GPR and CSR writes in the same cycle are legal (csrrw).
- Counter: instret increments by 1 on each commit_valid and wraps at 2^64-1 to 0.
- States:
  - S_IDLE: accepts. ecall goes to S_TRAP, mret to S_REDIRECT, ebreak to S_HALT, anything else stays in S_IDLE. Back-to-back accepts give 1 instruction/cycle.
  - S_TRAP (cycle T+1): commit_valid=1; trap_wen=1, trap_mepc=latched pc, trap_mcause=MCAUSE_ECALL. Samples csr_mtvec into the target register, then goes to S_REDIRECT.
  - S_REDIRECT, one cycle:
    - redirect_valid=1 and flush=1.
    - redirect_pc = mtvec captured in S_TRAP (ecall), or csr_mepc sampled at T (mret).
    - Then returns to S_IDLE.
    - For mret, commit occurs in this cycle, i.e. T+1.
  - S_HALT: commit_valid=1 on entry cycle (T+1); halt=1 from T+1 onward and is sticky. in_ready=0 until rst.
- Timing: ecall redirect appears at T+2, mret at T+1. in_ready stays low until the redirect cycle completes, so no younger instruction commits before flush.
- ecall and ebreak produce no GPR or CSR write, even if in_reg_wen or in_csr_wen is set.
- in_valid without in_ready is ignored; inputs are not latched.
- rst at any state, including mid-trap or halted, returns to S_IDLE in the next cycle, with pending pulses dropped and halt cleared.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding (S_IDLE, S_TRAP, S_REDIRECT, S_HALT)
  - CSR address constants (MSTATUS, MTVEC, MEPC, MCAUSE)
  - MCAUSE_ECALL
- One natural sub-module, wbu_trap_ctrl, contains the state machine plus trap_wen, redirect and flush generation. The commit/write datapath stays in wbu_pipeline.

Test Plan:
- Accept addi with pc=0x80000000, rd=5, result=0x1234, reg_wen=1 -> one cycle later rf_wen=1, rf_waddr=5, rf_wdata=0x1234, commit_valid=1, instret=1.
- Write to x0: reg_wen=1, rd=0, result=0xFFFF -> rf_wen stays 0; commit_valid=1; instret still increments.
- csrrw with csr_addr=0x305, csr_wdata=0x80001000, rd=3, result=0x0 -> at T+1 csr_wen=1, csr_waddr=0x305 and rf_wen=1 in the same cycle.
- ecall at pc=0x80000010 with csr_mtvec=0x80001000:
  - T+1: trap_wen=1, trap_mepc=0x80000010, trap_mcause=11.
  - T+2: redirect_valid=1, flush=1, redirect_pc=0x80001000.
  - in_ready low during T+1 and T+2.
- mret with csr_mepc=0x80000014 -> T+1: redirect_valid=1, flush=1, redirect_pc=0x80000014, commit_valid=1; back-to-back with a preceding addi gives two consecutive commit pulses.
- ebreak, then in_valid held high:
  - halt=1 from T+1 and in_ready stays 0.
  - Assert rst for one cycle -> halt=0, instret=0, in_ready=1 the next cycle.
